mc_control_fsm: RTL and testbench

- Multicycle control unit for the RV64 core.
- Sequences the shared ALU each cycle: it drives the 3-bit ALU operand-B select, the operand-A select and the ALU op, and it strobes every datapath register and memory enable.
- Supports a bounded instruction subset.
- Stalls on a memory ready handshake.
- Traps on illegal opcodes.

---
 rtl/mc_control_fsm.sv | 92 +++++++++
 tb/tb_mc_control_fsm.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RV64 control unit sequencing the shared ALU, datapath write enables and memory handshake
module mc_control_fsm #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alu_srcb_sel,
  output logic [1:0] alu_srca_sel,
  output logic [1:0] alu_op,
  output logic       pc_write,
  output logic       old_pc_write,
  output logic       ir_write,
  output logic       aluout_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       mdr_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [3:0] state_o,
  output logic       illegal_instr,
  output logic       mem_err
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3,
                         MEM_ADDR = 4'd4, MEM_RD = 4'd5, MEM_WR = 4'd6, WB_ALU = 4'd7,
                         WB_MEM = 4'd8, BRANCH = 4'd9, JAL = 4'd10, LUI = 4'd11, TRAP = 4'd15;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_SD = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_LUI = 7'b0110111;
  logic [3:0] state, nxt;
  logic [7:0] cnt;
  logic waiting, timeout, br_ok, take;
  assign waiting = (state == FETCH || state == MEM_RD || state == MEM_WR) && !mem_ready;
  assign timeout = waiting && cnt == 8'(MEM_TIMEOUT - 1);
  assign br_ok = funct3 == 3'b000 || funct3 == 3'b001;
  assign take = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
  always_comb begin
    nxt = state;
    case (state)
      FETCH:                 nxt = mem_ready ? DECODE : FETCH;
      DECODE:                nxt = opcode == OP_R ? EXEC_R :
                                   opcode == OP_I ? EXEC_I :
                                   (opcode == OP_LD || opcode == OP_SD) ? MEM_ADDR :
                                   opcode == OP_BR ? BRANCH :
                                   opcode == OP_JAL ? JAL :
                                   opcode == OP_LUI ? LUI : TRAP;
      EXEC_R, EXEC_I, LUI:   nxt = WB_ALU;
      MEM_ADDR:              nxt = opcode == OP_LD ? MEM_RD : MEM_WR;
      MEM_RD:                nxt = mem_ready ? WB_MEM : MEM_RD;
      MEM_WR:                nxt = mem_ready ? FETCH : MEM_WR;
      WB_ALU, WB_MEM, JAL:   nxt = FETCH;
      BRANCH:                nxt = br_ok ? FETCH : TRAP;
      default:               nxt = TRAP;
    endcase
    if (timeout) nxt = TRAP;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= FETCH;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= nxt != state ? '0 : waiting ? cnt + 8'd1 : cnt;
      mem_err <= mem_err | timeout;
    end
  end
  assign alu_srca_sel = (state == DECODE || state == JAL) ? 2'b10 :
                        (state == EXEC_R || state == EXEC_I || state == MEM_ADDR || state == BRANCH) ? 2'b01 :
                        state == LUI ? 2'b11 : 2'b00;
  assign alu_srcb_sel = state == FETCH ? 3'b001 :
                        state == DECODE ? 3'b011 :
                        (state == EXEC_I || state == MEM_ADDR || state == LUI) ? 3'b100 :
                        state == JAL ? 3'b101 : 3'b000;
  assign alu_op        = (state == EXEC_R || state == EXEC_I) ? 2'b10 : state == BRANCH ? 2'b01 : 2'b00;
  assign pc_write      = (state == FETCH && mem_ready) || state == JAL || (state == BRANCH && take);
  assign old_pc_write  = state == FETCH && mem_ready;
  assign ir_write      = state == FETCH && mem_ready;
  assign aluout_write  = state == DECODE || state == EXEC_R || state == EXEC_I || state == MEM_ADDR || state == LUI;
  assign mem_read      = state == FETCH || state == MEM_RD;
  assign mem_write     = state == MEM_WR;
  assign i_or_d        = state == MEM_RD || state == MEM_WR;
  assign mdr_write     = state == MEM_RD && mem_ready;
  assign reg_write     = state == WB_ALU || state == WB_MEM || state == JAL;
  assign wb_sel        = state == WB_MEM ? 2'b01 : state == JAL ? 2'b10 : 2'b00;
  assign state_o       = state;
  assign illegal_instr = state == TRAP;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: instruction-level plan generator feeding a scoreboard checked by a per-cycle monitor
module tb_mc_control_fsm;
  localparam int TO = 16;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_SD = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;
  localparam logic [8:0] PCW = 9'h100, OPW = 9'h080, IRW = 9'h040, AOW = 9'h020, MRD = 9'h010,
                         MWR = 9'h008, IOD = 9'h004, MDR = 9'h002, RGW = 9'h001;
  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        rdy;
    logic        rst_n;
    logic [23:0] exp;
  } cyc_t;
  logic clk = 1'b0, reset_n, zero, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [2:0] alu_srcb_sel;
  logic [1:0] alu_srca_sel, alu_op, wb_sel;
  logic pc_write, old_pc_write, ir_write, aluout_write, mem_read, mem_write, i_or_d, mdr_write, reg_write;
  logic [3:0] state_o;
  logic illegal_instr, mem_err;
  cyc_t plan[$];
  logic [23:0] sb[$];
  int checks = 0, errors = 0, k, rst_at, ncyc = 0;
  bit abort, m_ill = 0, m_merr = 0;
  always #5 clk = ~clk;
  mc_control_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .alu_srcb_sel(alu_srcb_sel), .alu_srca_sel(alu_srca_sel), .alu_op(alu_op), .pc_write(pc_write),
    .old_pc_write(old_pc_write), .ir_write(ir_write), .aluout_write(aluout_write), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .mdr_write(mdr_write), .reg_write(reg_write), .wb_sel(wb_sel),
    .state_o(state_o), .illegal_instr(illegal_instr), .mem_err(mem_err)
  );
  function automatic logic [21:0] ov(input logic [2:0] b, input logic [1:0] a, input logic [1:0] op,
                                     input logic [8:0] f, input logic [1:0] wb, input logic [3:0] st);
    return {b, a, op, f, wb, st};
  endfunction
  task automatic push(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic rdy,
                      input logic rs, input logic [21:0] o);
    cyc_t c;
    if (abort) return;
    c.op = op; c.f3 = f3; c.z = z; c.rdy = rdy;
    c.rst_n = !(rs || k == rst_at);
    c.exp = {o, m_ill, m_merr};
    plan.push_back(c);
    if (!c.rst_n) begin
      abort = 1; m_ill = 0; m_merr = 0;
    end
    k++;
  endtask
  task automatic nop(input logic [21:0] o);
    push(7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'b0, o);
  endtask
  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                       input int fw, input int mw, input int ra);
    bit tr = 0;
    k = 0; rst_at = ra; abort = 0;
    for (int i = 0; i < fw && !tr; i++) begin
      push(7'($urandom), 3'($urandom), 1'($urandom), 1'b0, 1'b0, ov(3'b001, 2'b00, 2'b00, MRD, 2'b00, 4'd0));
      if (i + 1 == TO) begin
        tr = 1;
        if (!abort) m_merr = 1;
      end
    end
    if (!tr) begin
      push(7'($urandom), 3'($urandom), 1'($urandom), 1'b1, 1'b0, ov(3'b001, 2'b00, 2'b00, PCW | OPW | IRW | MRD, 2'b00, 4'd0));
      push(op, 3'($urandom), 1'($urandom), 1'($urandom), 1'b0, ov(3'b011, 2'b10, 2'b00, AOW, 2'b00, 4'd1));
      case (op)
        OP_R: begin
          nop(ov(3'b000, 2'b01, 2'b10, AOW, 2'b00, 4'd2));
          nop(ov(3'b000, 2'b00, 2'b00, RGW, 2'b00, 4'd7));
        end
        OP_I: begin
          nop(ov(3'b100, 2'b01, 2'b10, AOW, 2'b00, 4'd3));
          nop(ov(3'b000, 2'b00, 2'b00, RGW, 2'b00, 4'd7));
        end
        OP_LD, OP_SD: begin
          push(op, 3'($urandom), 1'($urandom), 1'($urandom), 1'b0, ov(3'b100, 2'b01, 2'b00, AOW, 2'b00, 4'd4));
          for (int i = 0; i < mw && !tr; i++) begin
            push(7'($urandom), 3'($urandom), 1'($urandom), 1'b0, 1'b0,
                 op == OP_LD ? ov(3'b000, 2'b00, 2'b00, MRD | IOD, 2'b00, 4'd5) : ov(3'b000, 2'b00, 2'b00, MWR | IOD, 2'b00, 4'd6));
            if (i + 1 == TO) begin
              tr = 1;
              if (!abort) m_merr = 1;
            end
          end
          if (!tr && op == OP_LD) begin
            push(7'($urandom), 3'($urandom), 1'($urandom), 1'b1, 1'b0, ov(3'b000, 2'b00, 2'b00, MRD | IOD | MDR, 2'b00, 4'd5));
            nop(ov(3'b000, 2'b00, 2'b00, RGW, 2'b01, 4'd8));
          end else if (!tr)
            push(7'($urandom), 3'($urandom), 1'($urandom), 1'b1, 1'b0, ov(3'b000, 2'b00, 2'b00, MWR | IOD, 2'b00, 4'd6));
        end
        OP_BR: begin
          push(7'($urandom), f3, z, 1'($urandom), 1'b0,
               ov(3'b000, 2'b01, 2'b01, ((f3 == 0 && z) || (f3 == 1 && !z)) ? PCW : 9'h0, 2'b00, 4'd9));
          tr = f3 > 1;
        end
        OP_JAL: nop(ov(3'b101, 2'b10, 2'b00, PCW | RGW, 2'b10, 4'd10));
        OP_LUI: begin
          nop(ov(3'b100, 2'b11, 2'b00, AOW, 2'b00, 4'd11));
          nop(ov(3'b000, 2'b00, 2'b00, RGW, 2'b00, 4'd7));
        end
        default: tr = 1;
      endcase
    end
    if (tr && !abort) begin
      m_ill = 1;
      repeat (2) nop(ov(3'b000, 2'b00, 2'b00, 9'h0, 2'b00, 4'd15));
      push(7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'b1, ov(3'b000, 2'b00, 2'b00, 9'h0, 2'b00, 4'd15));
    end
  endtask
  always @(negedge clk) begin
    logic [23:0] act, want;
    if (sb.size() != 0) begin
      want = sb.pop_front();
      act = {alu_srcb_sel, alu_srca_sel, alu_op, pc_write, old_pc_write, ir_write, aluout_write, mem_read,
             mem_write, i_or_d, mdr_write, reg_write, wb_sel, state_o, illegal_instr, mem_err};
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL ctrl cycle %0d: got %h (state %0d) expected %h (state %0d)", ncyc, act, act[5:2], want, want[5:2]);
      end
    end
  end
  initial begin
    cyc_t c;
    logic [6:0] ops [8];
    reset_n = 0; opcode = 0; funct3 = 0; zero = 0; mem_ready = 0;
    ops = '{OP_R, OP_I, OP_LD, OP_SD, OP_BR, OP_JAL, OP_LUI, OP_BAD};
    k = 0; rst_at = -1; abort = 0;
    push(7'd0, 3'd0, 1'b0, 1'b0, 1'b1, ov(3'b001, 2'b00, 2'b00, MRD, 2'b00, 4'd0));
    instr(OP_R, 3'd0, 1'b0, 0, 0, -1);
    instr(OP_LD, 3'd3, 1'b0, 0, 3, -1);
    instr(OP_BR, 3'd0, 1'b1, 0, 0, -1);
    instr(OP_BR, 3'd0, 1'b0, 0, 0, -1);
    instr(OP_BR, 3'd1, 1'b0, 1, 0, -1);
    instr(OP_BR, 3'd5, 1'b1, 0, 0, -1);
    instr(OP_JAL, 3'd0, 1'b0, 2, 0, -1);
    instr(OP_BAD, 3'd0, 1'b0, 0, 0, -1);
    instr(OP_R, 3'd0, 1'b0, TO, 0, -1);
    instr(OP_R, 3'd0, 1'b0, TO - 1, 0, -1);
    instr(OP_LD, 3'd3, 1'b0, 0, TO, -1);
    instr(OP_SD, 3'd3, 1'b0, 0, TO - 1, -1);
    instr(OP_SD, 3'd3, 1'b0, 0, 3, 5);
    instr(OP_LUI, 3'd0, 1'b0, 0, 0, -1);
    for (int n = 0; n < 250; n++)
      instr($urandom_range(0, 9) == 0 ? 7'($urandom) : ops[$urandom_range(0, 7)],
            $urandom_range(0, 3) == 0 ? 3'($urandom) : 3'($urandom_range(0, 1)), 1'($urandom),
            $urandom_range(0, 29) == 0 ? TO : $urandom_range(0, 3),
            $urandom_range(0, 29) == 0 ? TO : $urandom_range(0, 3),
            $urandom_range(0, 7) == 0 ? $urandom_range(0, 6) : -1);
    repeat (2) @(posedge clk);
    #1;
    while (plan.size() != 0) begin
      c = plan.pop_front();
      reset_n = c.rst_n; opcode = c.op; funct3 = c.f3; zero = c.z; mem_ready = c.rdy;
      sb.push_back(c.exp);
      @(posedge clk);
      #1;
      ncyc++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles unchecked, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
